// File: rtl/music_rom_player_if.sv
// ROM read bus and codec write-FIFO handshake for music_rom_player.
// master = player side, slave = ROM/codec side.
interface music_rom_player_if;
    logic [15:0] rom_address;
    logic [7:0]  rom_q;
    logic        write_ready;
    logic        write;
    logic [23:0] sample_out;

    modport master (
        output rom_address, write, sample_out,
        input  rom_q, write_ready
    );

    modport slave (
        input  rom_address, write, sample_out,
        output rom_q, write_ready
    );
endinterface

// File: rtl/music_rom_player.sv
// Walks the music ROM, converts unsigned 8-bit samples to attenuated signed 24-bit ones
// and hands them to the codec FIFO. Optional wrap-around playback: MUSIC_ROM_PLAYER_LOOP_EN.
module music_rom_player #(
    parameter logic [15:0] LAST_ADDR   = 16'hFFFF,
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 play,
    input  logic                 restart,
    input  logic [2:0]           vol,
    music_rom_player_if.master   bus,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {IDLE, FETCH, HOLD, PUSH, DONE} state_e;

    localparam logic [1:0] LAT_LAST = 2'(ROM_LATENCY - 1);

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [1:0]  lat_q, lat_d;
    logic [23:0] sample_q, sample_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        write_s;

    logic signed [23:0] conv;
    assign conv = {bus.rom_q ^ 8'h80, 16'h0000};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            lat_q    <= '0;
            sample_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            lat_q    <= lat_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        lat_d    = lat_q;
        sample_d = sample_q;
        done_d   = done_q;
        write_s  = 1'b0;

        // restart overrides every state, including the PUSH strobe
        if (restart) begin
            addr_d  = '0;
            lat_d   = '0;
            done_d  = 1'b0;
            state_d = play ? FETCH : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    lat_d = '0;
                    if (play) state_d = FETCH;
                end
                FETCH: begin
                    if (!play) begin
                        lat_d   = '0;
                        state_d = IDLE;
                    end else if (lat_q == LAT_LAST) begin
                        sample_d = conv >>> vol;
                        lat_d    = '0;
                        state_d  = HOLD;
                    end else begin
                        lat_d = lat_q + 2'd1;
                    end
                end
                HOLD: begin
                    if (!play)            state_d = IDLE;
                    else if (bus.write_ready) state_d = PUSH;
                end
                PUSH: begin
                    write_s = 1'b1;
                    if (addr_q == LAST_ADDR) begin
`ifdef MUSIC_ROM_PLAYER_LOOP_EN
                        addr_d  = '0;
                        state_d = play ? FETCH : IDLE;
`else
                        done_d  = 1'b1;
                        state_d = DONE;
`endif
                    end else begin
                        addr_d  = addr_q + 16'd1;
                        state_d = play ? FETCH : IDLE;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE) && (state_d != DONE);
    end

    assign bus.rom_address = addr_q;
    assign bus.write       = write_s;
    assign bus.sample_out  = sample_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule
